clock_enable_gen: RTL and testbench

CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

---
 rtl/clock_enable_gen.sv | 104 ++++++++++
 tb/tb_clock_enable_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator: per-channel divider producing a
// tick strobe, a divided square wave and a phase-programmable latch strobe.
module clock_enable_gen #(
  parameter int CHANNELS     = 2,
  parameter int WIDTH        = 8,
  parameter int DEFAULT_DIV  = 3,
  parameter int DEFAULT_MARK = 1
) (
  input  logic                      clkin,
  input  logic                      RST_n,
  input  logic                      en,
  input  logic                      sync,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] div_in,
  input  logic [CHANNELS*WIDTH-1:0] mark_in,
  output logic [CHANNELS-1:0]       load_ack,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       latch_out
);

  // load/load_ack: load[i] is a single-cycle request with no ready; the divisor and mark
  // present that cycle are taken (a newer request overwrites an older unapplied one), and
  // load_ack[i] pulses for one cycle right after the edge where the values become active.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : gChan
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] divAct;
    logic [WIDTH-1:0] markAct;
    logic [WIDTH-1:0] divPend;
    logic [WIDTH-1:0] markPend;
    logic             pendValid;
    logic             tickQ;
    logic             clkQ;
    logic             latchQ;
    logic             ackQ;

    logic [WIDTH-1:0] divNew;
    logic [WIDTH-1:0] markNew;
    logic             wrapNow;
    logic             applyEdge;
    logic             doApply;

    always_comb begin
      divNew    = div_in[gi*WIDTH +: WIDTH];
      markNew   = mark_in[gi*WIDTH +: WIDTH];
      wrapNow   = en & (cnt == divAct);
      // New settings may only land where no period is cut short.
      applyEdge = sync | ~en | wrapNow;
      doApply   = applyEdge & (load[gi] | pendValid);
    end

    always_ff @(posedge clkin or negedge RST_n) begin
      if (!RST_n) begin
        cnt       <= '0;
        divAct    <= WIDTH'(DEFAULT_DIV);
        markAct   <= WIDTH'(DEFAULT_MARK);
        divPend   <= '0;
        markPend  <= '0;
        pendValid <= 1'b0;
        tickQ     <= 1'b0;
        clkQ      <= 1'b0;
        latchQ    <= 1'b0;
        ackQ      <= 1'b0;
      end else begin
        ackQ <= doApply;
        if (applyEdge) begin
          if (load[gi]) begin
            divAct  <= divNew;
            markAct <= markNew;
          end else if (pendValid) begin
            divAct  <= divPend;
            markAct <= markPend;
          end
          pendValid <= 1'b0;
        end else if (load[gi]) begin
          divPend   <= divNew;
          markPend  <= markNew;
          pendValid <= 1'b1;
        end

        if (sync) begin
          cnt    <= '0;
          tickQ  <= 1'b0;
          clkQ   <= 1'b0;
          latchQ <= 1'b0;
        end else if (en) begin
          cnt    <= wrapNow ? '0 : cnt + 1'b1;
          tickQ  <= wrapNow;
          latchQ <= (cnt == markAct);
          clkQ   <= (cnt <= (divAct >> 1));
        end else begin
          tickQ  <= 1'b0;
          latchQ <= 1'b0;
        end
      end
    end

    assign load_ack[gi]  = ackQ;
    assign tick[gi]      = tickQ;
    assign clk_out[gi]   = clkQ;
    assign latch_out[gi] = latchQ;
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Bench for clock_enable_gen: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural divider model.
module tb_clock_enable_gen;
  localparam int CH = 2;
  localparam int W  = 8;

  logic             clkin = 1'b0;
  logic             RST_n;
  logic             en;
  logic             sync;
  logic [CH-1:0]    load;
  logic [CH*W-1:0]  div_in;
  logic [CH*W-1:0]  mark_in;
  logic [CH-1:0]    load_ack;
  logic [CH-1:0]    tick;
  logic [CH-1:0]    clk_out;
  logic [CH-1:0]    latch_out;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clkin = ~clkin;

  clock_enable_gen #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(3), .DEFAULT_MARK(1)) dut (
    .clkin(clkin), .RST_n(RST_n), .en(en), .sync(sync), .load(load),
    .div_in(div_in), .mark_in(mark_in), .load_ack(load_ack), .tick(tick),
    .clk_out(clk_out), .latch_out(latch_out)
  );

  // ---------------- behavioural model ----------------
  int            m_cnt[CH];
  int            m_da[CH];
  int            m_ma[CH];
  int            m_dp[CH];
  int            m_mp[CH];
  bit            m_pend[CH];
  logic [CH-1:0] e_tick, e_clk, e_latch, e_ack;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_da[c] = 3; m_ma[c] = 1; m_dp[c] = 0; m_mp[c] = 0; m_pend[c] = 0;
    end
    e_tick = '0; e_clk = '0; e_latch = '0; e_ack = '0;
  endtask

  always @(posedge clkin or negedge RST_n) begin
    if (!RST_n) model_reset();
    else begin
      for (int c = 0; c < CH; c++) begin
        int  d, m;
        bit  at_end, may_apply;
        d = int'(div_in[c*W +: W]);
        m = int'(mark_in[c*W +: W]);
        at_end    = en && (m_cnt[c] == m_da[c]);
        may_apply = sync || !en || at_end;
        if (sync) begin
          e_tick[c] = 0; e_latch[c] = 0; e_clk[c] = 0;
        end else if (en) begin
          e_tick[c]  = at_end;
          e_latch[c] = (m_cnt[c] == m_ma[c]);
          e_clk[c]   = (m_cnt[c] <= m_da[c] / 2);
        end else begin
          e_tick[c] = 0; e_latch[c] = 0;
        end
        e_ack[c] = 0;
        if (may_apply && (load[c] || m_pend[c])) begin
          m_da[c]   = load[c] ? d : m_dp[c];
          m_ma[c]   = load[c] ? m : m_mp[c];
          m_pend[c] = 0;
          e_ack[c]  = 1;
        end else if (load[c]) begin
          m_dp[c] = d; m_mp[c] = m; m_pend[c] = 1;
        end
        if (sync) m_cnt[c] = 0;
        else if (en) m_cnt[c] = at_end ? 0 : (m_cnt[c] + 1) % (1 << W);
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clkin) begin
    if (cmp_on) begin
      check_vec("model_tick", 32'(tick), 32'(e_tick));
      check_vec("model_clk_out", 32'(clk_out), 32'(e_clk));
      check_vec("model_latch_out", 32'(latch_out), 32'(e_latch));
      check_vec("model_load_ack", 32'(load_ack), 32'(e_ack));
    end
  end

  // ---------------- driver helpers ----------------
  logic [31:0] s_tick[CH], s_clk[CH], s_latch[CH], s_ack[CH];

  task automatic clear_caps();
    for (int c = 0; c < CH; c++) begin
      s_tick[c] = '0; s_clk[c] = '0; s_latch[c] = '0; s_ack[c] = '0;
    end
  endtask

  task automatic capture(input int i);
    for (int c = 0; c < CH; c++) begin
      s_tick[c][i]  = tick[c];
      s_clk[c][i]   = clk_out[c];
      s_latch[c][i] = latch_out[c];
      s_ack[c][i]   = load_ack[c];
    end
  endtask

  task automatic set_load(input int ch, input int d, input int m);
    load[ch]            = 1'b1;
    div_in[ch*W +: W]   = W'(d);
    mark_in[ch*W +: W]  = W'(m);
  endtask

  task automatic next_edge();
    @(posedge clkin);
    #2;
  endtask

  task automatic sync_pulse();
    sync = 1'b1;
    next_edge();
    sync = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_tick"}, 32'(tick), 32'h0);
    check_vec({tag, "_clk_out"}, 32'(clk_out), 32'h0);
    check_vec({tag, "_latch_out"}, 32'(latch_out), 32'h0);
    check_vec({tag, "_load_ack"}, 32'(load_ack), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tq[$];
    RST_n = 1'b0; en = 1'b0; sync = 1'b0; load = '0; div_in = '0; mark_in = '0;
    repeat (2) next_edge();
    check_all_zero("reset");
    cmp_on = 1'b1;

    // Defaults after reset: period 4, clk 2 high / 2 low, latch after the cnt==1 edge
    RST_n = 1'b1; en = 1'b1;
    clear_caps();
    for (int i = 0; i < 8; i++) begin
      @(posedge clkin); @(negedge clkin); capture(i);
    end
    for (int c = 0; c < CH; c++) begin
      check_vec("dflt_tick", s_tick[c], 32'h88);
      check_vec("dflt_clk", s_clk[c], 32'h33);
      check_vec("dflt_latch", s_latch[c], 32'h22);
    end

    // Mid-period load D=5 on ch0: old period completes, then 6-cycle period
    sync_pulse();
    @(negedge clkin);
    check_vec("sync_tick", 32'(tick), 32'h0);
    check_vec("sync_clk", 32'(clk_out), 32'h0);
    check_vec("sync_latch", 32'(latch_out), 32'h0);
    clear_caps();
    for (int i = 0; i < 16; i++) begin
      next_edge();
      if (i == 0) set_load(0, 5, 1);
      if (i == 1) load = '0;
      @(negedge clkin); capture(i);
    end
    check_vec("ld5_tick", s_tick[0], 32'h8208);
    check_vec("ld5_clk", s_clk[0], 32'h1C73);
    check_vec("ld5_latch", s_latch[0], 32'h0822);
    check_vec("ld5_ack", s_ack[0], 32'h0008);

    // Two loads before the wrap: last one wins, single ack
    sync_pulse();
    clear_caps();
    for (int i = 0; i < 20; i++) begin
      next_edge();
      if (i == 0) set_load(0, 2, 0);
      if (i == 1) set_load(0, 7, 0);
      if (i == 2) load = '0;
      @(negedge clkin); capture(i);
    end
    check_vec("lastwin_tick", s_tick[0], 32'h2020);
    check_vec("lastwin_ack", s_ack[0], 32'h0020);

    // D=0 on ch0, D=255 on ch1 (loaded while disabled), then sync and run
    en = 1'b0;
    set_load(0, 0, 0); set_load(1, 255, 0);
    next_edge();
    load = '0;
    sync_pulse();
    en = 1'b1;
    clear_caps();
    for (int i = 0; i < 520; i++) begin
      @(posedge clkin); @(negedge clkin);
      if (i < 8) capture(i);
      if (tick[1]) tq.push_back(i);
    end
    check_vec("d0_tick", s_tick[0], 32'hFF);
    check_vec("d0_clk", s_clk[0], 32'hFF);
    check_vec("d255_count", 32'(tq.size()), 32'd2);
    if (tq.size() == 2) begin
      check_vec("d255_first", 32'(tq[0]), 32'd255);
      check_vec("d255_second", 32'(tq[1]), 32'd511);
    end

    // Ch0 D=3, ch1 D=5, sync: ticks coincide after 12 cycles
    en = 1'b0;
    set_load(0, 3, 3); set_load(1, 5, 0);
    next_edge();
    load = '0; en = 1'b1;
    sync_pulse();
    @(negedge clkin);
    check_vec("sync2_tick", 32'(tick), 32'h0);
    check_vec("sync2_clk", 32'(clk_out), 32'h0);
    check_vec("sync2_latch", 32'(latch_out), 32'h0);
    clear_caps();
    for (int i = 0; i < 12; i++) begin
      @(posedge clkin); @(negedge clkin); capture(i);
    end
    check_vec("align_tick0", s_tick[0], 32'h888);
    check_vec("align_tick1", s_tick[1], 32'h820);

    // Async reset mid-count with a load pending
    sync_pulse();
    next_edge();
    set_load(0, 9, 2);
    next_edge();
    load = '0;
    #1 RST_n = 1'b0;
    #1 check_all_zero("async_rst");
    repeat (2) next_edge();
    RST_n = 1'b1; en = 1'b1;
    clear_caps();
    for (int i = 0; i < 8; i++) begin
      @(posedge clkin); @(negedge clkin); capture(i);
    end
    check_vec("post_rst_tick", s_tick[0], 32'h88);
    check_vec("post_rst_clk", s_clk[0], 32'h33);
    check_vec("post_rst_ack", s_ack[0], 32'h0);

    // Randomized run against the model
    for (int i = 0; i < 2000; i++) begin
      next_edge();
      RST_n = (i != 1000);
      en    = (($urandom_range(0, 9)) != 0);
      sync  = (($urandom_range(0, 49)) == 0);
      for (int c = 0; c < CH; c++) begin
        int d, m;
        d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
        m = int'($urandom_range(0, (d + 2 > 255) ? 255 : d + 2));
        load[c] = 1'b0;
        if ($urandom_range(0, 7) == 0) set_load(c, d, m);
      end
    end
    next_edge();
    load = '0; sync = 1'b0; en = 1'b0;
    repeat (2) @(posedge clkin);
    @(negedge clkin);
    #1 cmp_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
